sdram_aref: RTL and testbench



---
 rtl/sdram_pkg.sv | 36 +++
 rtl/sdram_ref_timer.sv | 57 +++++
 rtl/sdram_aref.sv | 119 +++++++++++
 tb/tb_sdram_aref.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command encodings, address masks, default
// timing values and the auto-refresh state type.
package sdram_pkg;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_NOP          = 4'b0111;
    localparam logic [3:0] CMD_PRECHARGE    = 4'b0010;
    localparam logic [3:0] CMD_AUTO_REFRESH = 4'b0001;

    // A10 high selects all banks for PRECHARGE
    localparam logic [11:0] ADDR_A10 = 12'h400;

    // 15 us at 100 MHz covers 4096 rows in 64 ms
    localparam int DEF_REF_INTERVAL = 1500;
    localparam int DEF_TRP          = 2;
    localparam int DEF_TRFC         = 7;

    typedef enum logic [2:0] {
        AREF_IDLE,
        AREF_PRE,
        AREF_WAIT_TRP,
        AREF_REF1,
        AREF_WAIT_TRFC1,
        AREF_REF2,
        AREF_WAIT_TRFC2,
        AREF_DONE
    } aref_state_e;

    // Width of a counter that must hold values up to max(trp, trfc)
    function automatic int phaseWidth(input int trp, input int trfc);
        int m;
        m = (trp > trfc) ? trp : trfc;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/sdram_ref_timer.sv
// Refresh interval timer: free-running period counter that raises a refresh
// request on every wrap and flags a miss when a request is still pending.
module sdram_ref_timer
    import sdram_pkg::*;
#(
    parameter int REF_INTERVAL = DEF_REF_INTERVAL
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic init_done_i,
    input  logic ack_i,
    output logic req_o,
    output logic miss_o
);

    localparam int CW = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REF_INTERVAL - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          req_q, req_d;
    logic          miss_q, miss_d;
    logic          wrap;

    // Counter holds at zero until the SDRAM is initialised; a wrap that finds
    // the previous request unaccepted is recorded as a miss, not queued again.
    always_comb begin
        wrap  = 1'b0;
        cnt_d = cnt_q;
        if (!init_done_i) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            wrap  = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        req_d  = wrap | (req_q & ~ack_i);
        miss_d = miss_q | (wrap & req_q & ~ack_i);
    end

    // State registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            req_q  <= 1'b0;
            miss_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            req_q  <= req_d;
            miss_q <= miss_d;
        end
    end

    assign req_o  = req_q;
    assign miss_o = miss_q;

endmodule

// File: rtl/sdram_aref.sv
// SDRAM auto-refresh controller: requests the bus every refresh interval and,
// once granted, issues PRECHARGE ALL followed by two AUTO REFRESH commands.
module sdram_aref
    import sdram_pkg::*;
#(
    parameter int REF_INTERVAL = DEF_REF_INTERVAL,
    parameter int TRP          = DEF_TRP,
    parameter int TRFC         = DEF_TRFC
) (
    input  logic        sclk,
    input  logic        rst,
    input  logic        init_done,
    input  logic        aref_en,
    output logic        aref_req,
    output logic [3:0]  aref_cmd,
    output logic [11:0] aref_addr,
    output logic        aref_done,
    output logic        aref_miss
);

    localparam int PW = phaseWidth(TRP, TRFC);
    localparam logic [PW-1:0] TRP_LAST  = PW'(TRP - 1);
    localparam logic [PW-1:0] TRFC_LAST = PW'(TRFC - 1);

    aref_state_e   state_q;
    logic [PW-1:0] phase_q;
    logic [3:0]    cmd_q;
    logic [11:0]   addr_q;
    logic          done_q;
    logic          reqPending;
    logic          grantAccept;

    // A grant only counts when the FSM is idle and a request is outstanding
    assign grantAccept = (state_q == AREF_IDLE) && reqPending && aref_en;

    sdram_ref_timer #(
        .REF_INTERVAL(REF_INTERVAL)
    ) u_timer (
        .clk_i      (sclk),
        .rst_i      (rst),
        .init_done_i(init_done),
        .ack_i      (grantAccept),
        .req_o      (reqPending),
        .miss_o     (aref_miss)
    );

    // Refresh sequencer; command outputs are registered alongside the state
    // they belong to, so each command appears in the cycle its state is entered.
    always_ff @(posedge sclk) begin
        if (rst) begin
            state_q <= AREF_IDLE;
            phase_q <= '0;
            cmd_q   <= CMD_NOP;
            addr_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            cmd_q  <= CMD_NOP;
            addr_q <= '0;
            done_q <= 1'b0;
            case (state_q)
                AREF_IDLE: begin
                    if (grantAccept) begin
                        state_q <= AREF_PRE;
                        cmd_q   <= CMD_PRECHARGE;
                        addr_q  <= ADDR_A10;
                    end
                end
                AREF_PRE: begin
                    state_q <= AREF_WAIT_TRP;
                    phase_q <= '0;
                end
                AREF_WAIT_TRP: begin
                    if (phase_q == TRP_LAST) begin
                        state_q <= AREF_REF1;
                        cmd_q   <= CMD_AUTO_REFRESH;
                    end else begin
                        phase_q <= phase_q + 1'b1;
                    end
                end
                AREF_REF1: begin
                    state_q <= AREF_WAIT_TRFC1;
                    phase_q <= '0;
                end
                AREF_WAIT_TRFC1: begin
                    if (phase_q == TRFC_LAST) begin
                        state_q <= AREF_REF2;
                        cmd_q   <= CMD_AUTO_REFRESH;
                    end else begin
                        phase_q <= phase_q + 1'b1;
                    end
                end
                AREF_REF2: begin
                    state_q <= AREF_WAIT_TRFC2;
                    phase_q <= '0;
                end
                AREF_WAIT_TRFC2: begin
                    if (phase_q == TRFC_LAST) begin
                        state_q <= AREF_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        phase_q <= phase_q + 1'b1;
                    end
                end
                AREF_DONE: begin
                    state_q <= AREF_IDLE;
                end
                default: begin
                    state_q <= AREF_IDLE;
                end
            endcase
        end
    end

    assign aref_req  = reqPending;
    assign aref_cmd  = cmd_q;
    assign aref_addr = addr_q;
    assign aref_done = done_q;

endmodule

// File: tb/tb_sdram_aref.sv
// Testbench for sdram_aref: directed scenarios plus randomized traffic, all
// checked every cycle against a behavioural model of the refresh rules.
module tb_sdram_aref;

    localparam int RI       = 1500;
    localparam int T_RP     = 2;
    localparam int T_RFC    = 7;
    // Offsets from the PRECHARGE cycle: 0 = PRECHARGE, last = done pulse
    localparam int OFF_REF1 = 1 + T_RP;
    localparam int OFF_REF2 = 2 + T_RP + T_RFC;
    localparam int OFF_DONE = 3 + T_RP + 2 * T_RFC;

    localparam logic [3:0] NOP  = 4'b0111;
    localparam logic [3:0] PREC = 4'b0010;
    localparam logic [3:0] AREF = 4'b0001;

    logic        sclk;
    logic        rst;
    logic        init_done;
    logic        aref_en;
    logic        aref_req;
    logic [3:0]  aref_cmd;
    logic [11:0] aref_addr;
    logic        aref_done;
    logic        aref_miss;

    int checks;
    int errors;

    // Model state: cycles of continuous init_done, pending request, sticky
    // miss and the cycle at which the current refresh sequence started.
    int  tick;
    int  runLen;
    bit  mReq;
    bit  mMiss;
    bit  seqActive;
    int  seqStart;
    logic [18:0] expVec;

    sdram_aref dut (
        .sclk     (sclk),
        .rst      (rst),
        .init_done(init_done),
        .aref_en  (aref_en),
        .aref_req (aref_req),
        .aref_cmd (aref_cmd),
        .aref_addr(aref_addr),
        .aref_done(aref_done),
        .aref_miss(aref_miss)
    );

    // Free-running 100 MHz clock
    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    // Compare one observed value against its expectation and count it
    task automatic checkOutput(input string tag, input logic [18:0] got, input logic [18:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got {req,miss,done,cmd,addr}=%h expected=%h", tag, got, exp);
        end
    endtask

    // Advance the reference model by one rising edge with the sampled inputs
    task automatic modelStep(input bit r, input bit i, input bit e);
        bit idle;
        bit accept;
        bit wrap;
        int off;
        logic [3:0]  eCmd;
        logic [11:0] eAddr;
        logic        eDone;
        tick++;
        eCmd  = NOP;
        eAddr = 12'h000;
        eDone = 1'b0;
        if (r) begin
            runLen    = 0;
            mReq      = 1'b0;
            mMiss     = 1'b0;
            seqActive = 1'b0;
        end else begin
            idle   = !seqActive || ((tick - seqStart) > OFF_DONE + 1);
            accept = idle && mReq && e;
            wrap   = 1'b0;
            if (i) begin
                runLen++;
                wrap = ((runLen % RI) == 0);
            end else begin
                runLen = 0;
            end
            if (accept) begin
                seqActive = 1'b1;
                seqStart  = tick;
            end
            if (wrap && mReq && !accept) mMiss = 1'b1;
            mReq = wrap || (mReq && !accept);
            if (seqActive) begin
                off = tick - seqStart;
                if (off == 0) begin
                    eCmd  = PREC;
                    eAddr = 12'h400;
                end else if (off == OFF_REF1 || off == OFF_REF2) begin
                    eCmd = AREF;
                end else if (off == OFF_DONE) begin
                    eDone = 1'b1;
                end
            end
        end
        expVec = {mReq, mMiss, eDone, eCmd, eAddr};
    endtask

    // Drive one cycle of inputs, let the edge happen, then check all outputs
    task automatic applyStimulus(input bit r, input bit i, input bit e);
        rst       = r;
        init_done = i;
        aref_en   = e;
        @(posedge sclk);
        modelStep(r, i, e);
        #1;
        checkOutput($sformatf("cycle%0d", tick),
                    {aref_req, aref_miss, aref_done, aref_cmd, aref_addr}, expVec);
    endtask

    // Scenario sequence
    initial begin
        bit initLvl;
        checks    = 0;
        errors    = 0;
        tick      = 0;
        runLen    = 0;
        mReq      = 1'b0;
        mMiss     = 1'b0;
        seqActive = 1'b0;
        seqStart  = 0;
        rst       = 1'b1;
        init_done = 1'b0;
        aref_en   = 1'b0;
        #2;

        // Reset state
        applyStimulus(1, 0, 0);
        applyStimulus(1, 0, 0);

        // No grants: request at 1500, miss at 3000, request stays high
        for (int c = 1; c <= 3100; c++) applyStimulus(0, 1, 0);

        // Stray grant while idle, then a real grant at cycle 1600
        applyStimulus(1, 0, 0);
        for (int c = 1; c <= 1700; c++) applyStimulus(0, 1, (c == 11) || (c == 1601));

        // Reset five cycles after a grant aborts the sequence
        applyStimulus(1, 0, 0);
        for (int c = 1; c <= 1605; c++) applyStimulus(0, 1, (c == 1601));
        applyStimulus(1, 1, 0);
        for (int c = 1; c <= 1510; c++) applyStimulus(0, 1, 0);

        // SDRAM never initialised: no requests whatever the grant does
        applyStimulus(1, 0, 0);
        for (int c = 1; c <= 5000; c++) applyStimulus(0, 0, ($urandom_range(0, 9) == 0));

        // Grant, then init_done drops mid-sequence
        applyStimulus(1, 0, 0);
        for (int c = 1; c <= 1640; c++) applyStimulus(0, (c < 1605), (c == 1601));

        // Randomized traffic with sparse grants, init drops and resets
        applyStimulus(1, 0, 0);
        initLvl = 1'b1;
        for (int c = 1; c <= 12000; c++) begin
            if (initLvl && $urandom_range(0, 2999) == 0) initLvl = 1'b0;
            else if (!initLvl && $urandom_range(0, 19) == 0) initLvl = 1'b1;
            applyStimulus(($urandom_range(0, 3999) == 0), initLvl, ($urandom_range(0, 99) < 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
